// File: rtl/bus_arbiter_rr3.sv
// rtl/bus_arbiter_rr3.sv - three-master round-robin system bus arbiter with slave timeout
module bus_arbiter_rr3 #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  input  logic [31:0] i_pb_wdata,
  input  logic        i_pc_rw,
  input  logic        i_pc_request,
  output logic        o_pc_ready,
  input  logic [31:0] i_pc_address,
  output logic [31:0] o_pc_rdata,
  input  logic [31:0] i_pc_wdata,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] PORT_A = 2'd0;
  localparam logic [1:0] PORT_B = 2'd1;
  localparam logic [1:0] PORT_C = 2'd2;

  // A zero TIMEOUT disables the watchdog; otherwise completion is forced on the last allowed cycle
  localparam logic        TMO_EN     = (TIMEOUT != 32'd0);
  localparam int unsigned TMO_LAST_I = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  localparam logic [15:0] TMO_LAST   = TMO_LAST_I[15:0];

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  rdy_q, rdy_d;
  logic [31:0] rdata_a_q, rdata_a_d;
  logic [31:0] rdata_b_q, rdata_b_d;
  logic [31:0] rdata_c_q, rdata_c_d;
  logic        timeout_q, timeout_d;

  logic [2:0]  req_vec;
  logic [1:0]  winner;
  logic        tmo_hit;
  logic        complete;
  logic [31:0] cpl_data;

  assign req_vec  = {i_pc_request, i_pb_request, i_pa_request};
  assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST);
  assign complete = (state_q == ST_ACTIVE) && (i_bus_ready || tmo_hit);
  assign cpl_data = i_bus_ready ? i_bus_rdata : 32'd0;

  // Round-robin pick: first requesting port after the last grant, scanning A->B->C->A
  always_comb begin
    winner = PORT_A;
    case (last_q)
      PORT_A: begin
        if (req_vec[1])      winner = PORT_B;
        else if (req_vec[2]) winner = PORT_C;
        else                 winner = PORT_A;
      end
      PORT_B: begin
        if (req_vec[2])      winner = PORT_C;
        else if (req_vec[0]) winner = PORT_A;
        else                 winner = PORT_B;
      end
      default: begin
        if (req_vec[0])      winner = PORT_A;
        else if (req_vec[1]) winner = PORT_B;
        else                 winner = PORT_C;
      end
    endcase
  end

  // Sequencer: grant in IDLE, hold the bus in ACTIVE, spend one RELEASE cycle showing the ready pulse
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    bus_rw_d    = bus_rw_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdy_d       = 3'b000;
    rdata_a_d   = rdata_a_q;
    rdata_b_d   = rdata_b_q;
    rdata_c_d   = rdata_c_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          grant_d   = winner;
          last_d    = winner;
          cnt_d     = 16'd0;
          bus_req_d = 1'b1;
          state_d   = ST_ACTIVE;
          case (winner)
            PORT_A: begin
              bus_addr_d  = i_pa_address;
              bus_rw_d    = 1'b0;
              bus_wdata_d = 32'd0;
            end
            PORT_B: begin
              bus_addr_d  = i_pb_address;
              bus_rw_d    = i_pb_rw;
              bus_wdata_d = i_pb_wdata;
            end
            default: begin
              bus_addr_d  = i_pc_address;
              bus_rw_d    = i_pc_rw;
              bus_wdata_d = i_pc_wdata;
            end
          endcase
        end
      end
      ST_ACTIVE: begin
        if (complete) begin
          bus_req_d = 1'b0;
          timeout_d = ~i_bus_ready;
          state_d   = ST_RELEASE;
          case (grant_q)
            PORT_A: begin
              rdy_d[0]  = 1'b1;
              rdata_a_d = cpl_data;
            end
            PORT_B: begin
              rdy_d[1]  = 1'b1;
              rdata_b_d = cpl_data;
            end
            default: begin
              rdy_d[2]  = 1'b1;
              rdata_c_d = cpl_data;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction and parks last grant on C so A wins first
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_C;
      grant_q     <= PORT_A;
      cnt_q       <= 16'd0;
      bus_rw_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rdy_q       <= 3'b000;
      rdata_a_q   <= 32'd0;
      rdata_b_q   <= 32'd0;
      rdata_c_q   <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      bus_rw_q    <= bus_rw_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdy_q       <= rdy_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
      rdata_c_q   <= rdata_c_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_bus_rw      = bus_rw_q;
  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_pa_ready    = rdy_q[0];
  assign o_pb_ready    = rdy_q[1];
  assign o_pc_ready    = rdy_q[2];
  assign o_pa_rdata    = rdata_a_q;
  assign o_pb_rdata    = rdata_b_q;
  assign o_pc_rdata    = rdata_c_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr3.sv
// tb/tb_bus_arbiter_rr3.sv - self-checking bench for bus_arbiter_rr3
module tb_bus_arbiter_rr3;

  localparam int TMO = 8;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        o_bus_rw, o_bus_request, o_timeout;
  logic        i_bus_ready = 1'b0;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [31:0] i_bus_rdata = 32'd0;
  logic        o_pa_ready, o_pb_ready, o_pc_ready;
  logic [31:0] o_pa_rdata, o_pb_rdata, o_pc_rdata;

  logic [2:0]  req = 3'b000;
  logic [31:0] m_addr  [3];
  logic        m_rw    [3];
  logic [31:0] m_wdata [3];
  logic [31:0] tb_rd   [3];
  logic [2:0]  rdy_obs;
  logic [31:0] rd_obs  [3];

  assign rdy_obs   = {o_pc_ready, o_pb_ready, o_pa_ready};
  assign rd_obs[0] = o_pa_rdata;
  assign rd_obs[1] = o_pb_rdata;
  assign rd_obs[2] = o_pc_rdata;

  always #5 i_clock = ~i_clock;

  bus_arbiter_rr3 #(.TIMEOUT(TMO)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_bus_rw      (o_bus_rw),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_bus_wdata   (o_bus_wdata),
    .i_pa_request  (req[0]),
    .o_pa_ready    (o_pa_ready),
    .i_pa_address  (m_addr[0]),
    .o_pa_rdata    (o_pa_rdata),
    .i_pb_rw       (m_rw[1]),
    .i_pb_request  (req[1]),
    .o_pb_ready    (o_pb_ready),
    .i_pb_address  (m_addr[1]),
    .o_pb_rdata    (o_pb_rdata),
    .i_pb_wdata    (m_wdata[1]),
    .i_pc_rw       (m_rw[2]),
    .i_pc_request  (req[2]),
    .o_pc_ready    (o_pc_ready),
    .i_pc_address  (m_addr[2]),
    .o_pc_rdata    (o_pc_rdata),
    .i_pc_wdata    (m_wdata[2]),
    .o_timeout     (o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check($sformatf("%s flags", nm), {26'd0, o_bus_rw, o_bus_request, o_timeout, rdy_obs}, 32'd0);
    check($sformatf("%s bus addr", nm), o_bus_address, 32'd0);
    check($sformatf("%s bus wdata", nm), o_bus_wdata, 32'd0);
    check($sformatf("%s pa rdata", nm), o_pa_rdata, 32'd0);
    check($sformatf("%s pb rdata", nm), o_pb_rdata, 32'd0);
    check($sformatf("%s pc rdata", nm), o_pc_rdata, 32'd0);
  endtask

  task automatic do_reset();
    #2 i_reset = 1'b1;
    #1 check_zero("reset async");
    step();
    check_zero("reset held");
    req         = 3'b000;
    i_bus_ready = 1'b0;
    i_reset     = 1'b0;
    for (int p = 0; p < 3; p++) tb_rd[p] = 32'd0;
  endtask

  typedef struct packed {
    int          port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] sdata;
    logic        exp_rw;
    logic [31:0] exp_wdata;
    int          exp_cycles;
    logic        exp_tmo;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    int waited, hi;
    bit done, held_bad;
    m_addr[v.port]  = v.addr;
    m_rw[v.port]    = v.rw;
    m_wdata[v.port] = v.wdata;
    req[v.port]     = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!o_bus_request && waited < 10);
    check($sformatf("v%0d grant latency", idx), waited, 1);
    check($sformatf("v%0d bus addr", idx), o_bus_address, v.addr);
    check($sformatf("v%0d bus rw", idx), o_bus_rw, v.exp_rw);
    check($sformatf("v%0d bus wdata", idx), o_bus_wdata, v.exp_wdata);
    hi = 0; done = 0; held_bad = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (o_bus_request) begin
        hi++;
        if (o_bus_address !== v.addr || o_bus_rw !== v.exp_rw || o_bus_wdata !== v.exp_wdata) held_bad = 1;
      end
      i_bus_ready = (v.lat >= 0 && c == v.lat);
      i_bus_rdata = i_bus_ready ? v.sdata : 32'hBAD0_BAD0;
      step();
      if (rdy_obs != 3'b000 || o_timeout) done = 1;
    end
    i_bus_ready = 1'b0;
    tb_rd[v.port] = v.exp_rdata;
    check($sformatf("v%0d ready", idx), {29'd0, rdy_obs}, 32'(1 << v.port));
    check($sformatf("v%0d timeout", idx), o_timeout, v.exp_tmo);
    check($sformatf("v%0d request cycles", idx), hi, v.exp_cycles);
    check($sformatf("v%0d held stable", idx), held_bad, 0);
    for (int p = 0; p < 3; p++) check($sformatf("v%0d rdata p%0d", idx, p), rd_obs[p], tb_rd[p]);
    req[v.port] = 1'b0;
    step();
    check($sformatf("v%0d pulse width", idx), {29'd0, o_bus_request, o_timeout, |rdy_obs}, 32'd0);
  endtask

  task automatic serve(input int p, input int lat, input logic [31:0] sd, input bit keep_req,
                       input string nm, output int gap);
    int w;
    w = 0;
    while (!o_bus_request && w < 12) begin
      step();
      w++;
    end
    gap = w;
    check($sformatf("%s granted", nm), o_bus_request, 1);
    check($sformatf("%s grant addr", nm), o_bus_address, m_addr[p]);
    for (int c = 0; c < lat; c++) step();
    i_bus_ready = 1'b1;
    i_bus_rdata = sd;
    step();
    i_bus_ready = 1'b0;
    check($sformatf("%s ready", nm), {29'd0, rdy_obs}, 32'(1 << p));
    check($sformatf("%s rdata", nm), rd_obs[p], sd);
    tb_rd[p] = sd;
    if (!keep_req) req[p] = 1'b0;
  endtask

  int          g, w, hi;
  int          m_busy, m_win, m_cnt, m_lat, m_gap, m_last;
  logic [31:0] m_sdata;
  logic [2:0]  req_s, exp_rdy;
  logic        exp_to, exp_breq;

  initial begin
    for (int p = 0; p < 3; p++) begin
      m_addr[p] = 32'd0; m_rw[p] = 1'b0; m_wdata[p] = 32'd0; tb_rd[p] = 32'd0;
    end
    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 32'h0,         4, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h0001_0004, 32'h1234_5678, 1, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 2, 1'b0, 32'hA5A5_A5A5};
    vecs[2] = '{2, 1'b0, 32'h6000_0000, 32'h0,        -1, 32'h0,         1'b0, 32'h0,         8, 1'b1, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h0000_0200, 32'h0,         0, 32'h0BAD_F00D, 1'b0, 32'h0,         1, 1'b0, 32'h0BAD_F00D};
    vecs[4] = '{2, 1'b1, 32'h4000_0010, 32'hCAFE_F00D, 2, 32'h1111_2222, 1'b1, 32'hCAFE_F00D, 3, 1'b0, 32'h1111_2222};
    vecs[5] = '{1, 1'b0, 32'h2000_0000, 32'h7777_7777, 7, 32'h55AA_55AA, 1'b0, 32'h7777_7777, 8, 1'b0, 32'h55AA_55AA};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // stray slave strobe while idle
    i_bus_ready = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    step();
    i_bus_ready = 1'b0;
    step();
    check("idle strobe flags", {29'd0, o_bus_request, |rdy_obs, o_timeout}, 32'd0);
    check("idle strobe pa rdata", o_pa_rdata, tb_rd[0]);

    // simultaneous A,B,C; A re-requests straight away
    do_reset();
    m_addr[0] = 32'h1000_0000; m_addr[1] = 32'h2000_0000; m_addr[2] = 32'h3000_0000;
    m_rw[1] = 1'b1; m_rw[2] = 1'b0;
    req = 3'b111;
    serve(0, 0, 32'hA000_0001, 1'b1, "rr A1", g);
    serve(1, 1, 32'hB000_0001, 1'b0, "rr B", g);
    check("rr B gap", g, 2);
    serve(2, 0, 32'hC000_0001, 1'b0, "rr C", g);
    serve(0, 2, 32'hA000_0002, 1'b0, "rr A2", g);

    // C times out while A waits
    step();
    m_addr[2] = 32'h6000_0000; req[2] = 1'b1;
    w = 0;
    while (!o_bus_request && w < 12) begin step(); w++; end
    check("tmo grant C", o_bus_address, 32'h6000_0000);
    m_addr[0] = 32'h1000_0040; req[0] = 1'b1;
    hi = 0; w = 0;
    while (rdy_obs == 3'b000 && w < 20) begin
      if (o_bus_request) hi++;
      step();
      w++;
    end
    check("tmo request cycles", hi, 8);
    check("tmo ready and flag", {28'd0, o_timeout, rdy_obs}, 32'hC);
    check("tmo pc rdata", o_pc_rdata, 32'd0);
    req[2] = 1'b0; tb_rd[2] = 32'd0;
    serve(0, 1, 32'h0000_A0A0, 1'b0, "tmo next A", g);
    check("tmo next gap", g, 2);

    // reset while a B read is in flight
    step();
    m_addr[1] = 32'h2000_0100; m_rw[1] = 1'b0; req[1] = 1'b1;
    w = 0;
    while (!o_bus_request && w < 12) begin step(); w++; end
    step();
    do_reset();
    m_addr[0] = 32'h1000_0080;
    req = 3'b011;
    serve(0, 0, 32'h0101_0101, 1'b0, "post-reset A", g);
    serve(1, 0, 32'h0202_0202, 1'b0, "post-reset B", g);

    // A holds its request continuously against B
    do_reset();
    req = 3'b011;
    serve(0, 0, 32'hAAAA_0001, 1'b1, "hold A1", g);
    serve(1, 0, 32'hBBBB_0001, 1'b1, "hold B1", g);
    check("hold B1 gap", g, 2);
    serve(0, 1, 32'hAAAA_0002, 1'b1, "hold A2", g);
    check("hold A2 gap", g, 2);
    serve(1, 0, 32'hBBBB_0002, 1'b0, "hold B2", g);
    check("hold B2 gap", g, 2);

    // randomized traffic against a transaction-level model
    do_reset();
    m_last = 2; m_busy = 0; m_gap = 0; m_win = 0; m_cnt = 0; m_lat = 0; m_sdata = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_s = req;
      step();
      exp_rdy = 3'b000; exp_to = 1'b0; exp_breq = 1'b0;
      if (m_busy != 0) begin
        m_cnt++;
        if ((m_lat >= 0) ? (m_cnt == m_lat + 1) : (m_cnt == TMO)) begin
          exp_rdy[m_win] = 1'b1;
          exp_to = (m_lat < 0);
          tb_rd[m_win] = (m_lat < 0) ? 32'd0 : m_sdata;
          m_busy = 0;
          m_gap = 1;
        end else begin
          exp_breq = 1'b1;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req_s != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (m_busy == 0 && req_s[(m_last + k) % 3]) begin
            m_win = (m_last + k) % 3;
            m_busy = 1;
          end
        end
        m_last = m_win; m_cnt = 0; exp_breq = 1'b1;
        m_lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      end
      check("rnd ready", {28'd0, o_timeout, rdy_obs}, {28'd0, exp_to, exp_rdy});
      check("rnd bus request", o_bus_request, exp_breq);
      if (exp_breq) begin
        check("rnd bus addr", o_bus_address, m_addr[m_win]);
        check("rnd bus rw/wdata", {o_bus_rw, o_bus_wdata[30:0]},
              (m_win == 0) ? 32'd0 : {m_rw[m_win], m_wdata[m_win][30:0]});
      end
      for (int p = 0; p < 3; p++) check("rnd rdata", rd_obs[p], tb_rd[p]);
      for (int p = 0; p < 3; p++) begin
        if (exp_rdy[p]) begin
          req[p] = 1'b0;
        end else if (!(m_busy != 0 && m_win == p)) begin
          if (req[p]) begin
            if ($urandom_range(0, 19) == 0) req[p] = 1'b0;
          end else begin
            m_addr[p] = $urandom; m_rw[p] = 1'($urandom_range(0, 1)); m_wdata[p] = $urandom;
            if ($urandom_range(0, 2) == 0) req[p] = 1'b1;
          end
        end
      end
      i_bus_ready = 1'b0;
      i_bus_rdata = $urandom;
      if (m_busy != 0) begin
        if (m_lat >= 0 && m_cnt == m_lat) begin
          i_bus_ready = 1'b1;
          m_sdata = i_bus_rdata;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        i_bus_ready = 1'b1;
      end
    end
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
